// File: rtl/rename_status_file.sv
// Rename status file: architectural values plus per-register busy/tag
// rename state, combinational query ports with same-cycle bypass, in-order
// commit ports, and a circular stack of rename checkpoints for branch
// recovery.
module rename_status_file #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int TAG_BITS   = 4,
  parameter int NUM_QRY    = 2,
  parameter int NUM_COMMIT = 2,
  parameter int CKPT_DEPTH = 4,
  localparam int RB = $clog2(NREG),
  localparam int CB = $clog2(CKPT_DEPTH)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic [NUM_COMMIT-1:0]          commit_valid,
  input  logic [NUM_COMMIT*RB-1:0]       commit_rd,
  input  logic [NUM_COMMIT*TAG_BITS-1:0] commit_tag,
  input  logic [NUM_COMMIT*XLEN-1:0]     commit_val,
  input  logic                           disp_valid,
  input  logic [RB-1:0]                  disp_rd,
  input  logic [TAG_BITS-1:0]            disp_tag,
  input  logic [NUM_QRY*RB-1:0]          qry_id,
  output logic [NUM_QRY*XLEN-1:0]        qry_val,
  output logic [NUM_QRY*TAG_BITS-1:0]    qry_tag,
  output logic [NUM_QRY-1:0]             qry_busy,
  input  logic                           ckpt_save,
  output logic [CB-1:0]                  ckpt_id,
  output logic                           ckpt_full,
  input  logic                           ckpt_restore,
  input  logic [CB-1:0]                  ckpt_restore_id,
  input  logic                           ckpt_release
);

  logic [NREG-1:0][XLEN-1:0]                      val_q, val_d;
  logic [NREG-1:0]                                busy_q, busy_d;
  logic [NREG-1:0][TAG_BITS-1:0]                  tag_q, tag_d;
  logic [CKPT_DEPTH-1:0][NREG-1:0]                ck_busy_q, ck_busy_d;
  logic [CKPT_DEPTH-1:0][NREG-1:0][TAG_BITS-1:0]  ck_tag_q, ck_tag_d;
  logic [CKPT_DEPTH-1:0]                          ck_valid_q, ck_valid_d;
  logic [CB-1:0]                                  head_q, head_d;
  logic [CB-1:0]                                  tail_q, tail_d;
  logic [CB:0]                                    count_q, count_d;

  logic [NUM_COMMIT-1:0] cm_en;
  logic [RB-1:0]         cm_rd  [NUM_COMMIT];
  logic [TAG_BITS-1:0]   cm_tag [NUM_COMMIT];
  logic [XLEN-1:0]       cm_val [NUM_COMMIT];

  logic                  disp_en;
  logic                  do_restore, do_save, do_release, do_disp;
  logic [CB-1:0]         restore_off;

  logic [RB-1:0]         q_id;
  logic [XLEN-1:0]       q_val;
  logic [TAG_BITS-1:0]   q_tag;
  logic                  q_busy;

  assign ckpt_full   = (count_q == (CB+1)'(CKPT_DEPTH));
  assign ckpt_id     = tail_q;
  assign disp_en     = disp_valid && (disp_rd != '0);
  // Distance of the restored slot from the oldest live slot; slots at or
  // beyond this distance are the restored one and everything younger.
  assign restore_off = ckpt_restore_id - head_q;

  // Unpack commit ports; writes to register 0 are dropped at the source.
  always_comb begin
    cm_en = '0;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      cm_rd[k]  = commit_rd[k*RB +: RB];
      cm_tag[k] = commit_tag[k*TAG_BITS +: TAG_BITS];
      cm_val[k] = commit_val[k*XLEN +: XLEN];
      cm_en[k]  = commit_valid[k] && (commit_rd[k*RB +: RB] != '0);
    end
  end

  // Query ports: dispatch > youngest commit > stored state, value bypass
  // from commits applies even when a dispatch matches.
  always_comb begin
    qry_val  = '0;
    qry_tag  = '0;
    qry_busy = '0;
    q_id     = '0;
    q_val    = '0;
    q_tag    = '0;
    q_busy   = 1'b0;
    for (int q = 0; q < NUM_QRY; q++) begin
      q_id   = qry_id[q*RB +: RB];
      q_val  = val_q[q_id];
      q_tag  = tag_q[q_id];
      q_busy = busy_q[q_id];
      for (int k = 0; k < NUM_COMMIT; k++) begin
        if (cm_en[k] && (cm_rd[k] == q_id)) begin
          q_val = cm_val[k];
          if (cm_tag[k] == tag_q[q_id]) q_busy = 1'b0;
        end
      end
      if (disp_en && (disp_rd == q_id)) begin
        q_busy = 1'b1;
        q_tag  = disp_tag;
      end
      if (q_id == '0) begin
        q_val  = '0;
        q_tag  = '0;
        q_busy = 1'b0;
      end
      qry_val[q*XLEN +: XLEN]          = q_val;
      qry_tag[q*TAG_BITS +: TAG_BITS]  = q_tag;
      qry_busy[q]                      = q_busy;
    end
  end

  // Next-state for values, live rename table and checkpoint stack.
  always_comb begin
    val_d      = val_q;
    busy_d     = busy_q;
    tag_d      = tag_q;
    ck_busy_d  = ck_busy_q;
    ck_tag_d   = ck_tag_q;
    ck_valid_d = ck_valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    // An invalid restore slot makes the restore a no-op for the whole cycle.
    do_restore = ckpt_restore && ck_valid_q[ckpt_restore_id] && !flush_in;
    do_save    = ckpt_save && !ckpt_full && !flush_in && !do_restore;
    do_release = ckpt_release && (count_q != '0) && !flush_in && !ckpt_restore;
    do_disp    = disp_en && !flush_in && !do_restore;

    if (rdy_in) begin
      // Younger ports come later in the loop and win on the same rd.
      for (int k = 0; k < NUM_COMMIT; k++)
        if (cm_en[k]) val_d[cm_rd[k]] = cm_val[k];

      if (do_restore) begin
        busy_d = ck_busy_q[ckpt_restore_id];
        tag_d  = ck_tag_q[ckpt_restore_id];
      end

      // Commit-clears compare against the (possibly restored) tags.
      for (int k = 0; k < NUM_COMMIT; k++)
        if (cm_en[k] && (tag_d[cm_rd[k]] == cm_tag[k])) busy_d[cm_rd[k]] = 1'b0;

      if (do_disp) begin
        busy_d[disp_rd] = 1'b1;
        tag_d[disp_rd]  = disp_tag;
      end

      // Retired producers must never come back through a restore.
      for (int s = 0; s < CKPT_DEPTH; s++)
        for (int k = 0; k < NUM_COMMIT; k++)
          if (ck_valid_q[s] && cm_en[k] && (ck_tag_q[s][cm_rd[k]] == cm_tag[k]))
            ck_busy_d[s][cm_rd[k]] = 1'b0;

      if (do_restore) begin
        for (int s = 0; s < CKPT_DEPTH; s++)
          if ((CB'(s) - head_q) >= restore_off) ck_valid_d[s] = 1'b0;
        tail_d  = ckpt_restore_id;
        count_d = {1'b0, restore_off};
      end else begin
        if (do_release) begin
          ck_valid_d[head_q] = 1'b0;
          head_d             = head_q + 1'b1;
        end
        if (do_save) begin
          ck_busy_d[tail_q]  = busy_d;
          ck_tag_d[tail_q]   = tag_d;
          ck_valid_d[tail_q] = 1'b1;
          tail_d             = tail_q + 1'b1;
        end
        count_d = count_q + (CB+1)'(do_save) - (CB+1)'(do_release);
      end

      if (flush_in) begin
        busy_d     = '0;
        ck_valid_d = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_q      <= '0;
      busy_q     <= '0;
      tag_q      <= '0;
      ck_busy_q  <= '0;
      ck_tag_q   <= '0;
      ck_valid_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      val_q      <= val_d;
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      ck_busy_q  <= ck_busy_d;
      ck_tag_q   <= ck_tag_d;
      ck_valid_q <= ck_valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_rename_status_file.sv
// Directed bench for rename_status_file with default parameters.
module tb_rename_status_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [7:0]  commit_tag;
  logic [63:0] commit_val;
  logic        disp_valid;
  logic [4:0]  disp_rd;
  logic [3:0]  disp_tag;
  logic [9:0]  qry_id;
  logic [63:0] qry_val;
  logic [7:0]  qry_tag;
  logic [1:0]  qry_busy;
  logic        ckpt_save;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic        ckpt_release;

  int checks = 0;
  int errors = 0;

  wire [31:0] v0 = qry_val[31:0];
  wire [31:0] v1 = qry_val[63:32];
  wire [3:0]  t0 = qry_tag[3:0];
  wire [3:0]  t1 = qry_tag[7:4];
  wire        b0 = qry_busy[0];
  wire        b1 = qry_busy[1];

  rename_status_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val), .disp_valid(disp_valid), .disp_rd(disp_rd),
    .disp_tag(disp_tag), .qry_id(qry_id), .qry_val(qry_val), .qry_tag(qry_tag),
    .qry_busy(qry_busy), .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
    .ckpt_full(ckpt_full), .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id), .ckpt_release(ckpt_release)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0;
    commit_valid = '0; commit_rd = '0; commit_tag = '0; commit_val = '0;
    disp_valid = 1'b0; disp_rd = '0; disp_tag = '0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0; ckpt_release = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in); #1;
    idle();
    #1;
  endtask

  task automatic qry(input int port, input logic [4:0] id);
    qry_id[port*5 +: 5] = id;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [3:0] tag);
    disp_valid = 1'b1; disp_rd = rd; disp_tag = tag;
  endtask

  task automatic cmt(input int port, input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
    commit_valid[port] = 1'b1;
    commit_rd[port*5 +: 5] = rd;
    commit_tag[port*4 +: 4] = tag;
    commit_val[port*32 +: 32] = val;
  endtask

  task automatic test_reset();
    idle(); rst_in = 1'b1; qry_id = '0; qry(0, 5); qry(1, 7);
    #12;
    checks++; if (v0 !== 32'h0) begin errors++; $display("FAIL reset_val: got %h expected %h", v0, 32'h0); end
    checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", b0, 1'b0); end
    checks++; if (t1 !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected %h", t1, 4'h0); end
    checks++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected %b", ckpt_full, 1'b0); end
    checks++; if (ckpt_id !== 2'd0) begin errors++; $display("FAIL reset_ckpt_id: got %0d expected %0d", ckpt_id, 0); end
    rst_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_basic();
    qry(0, 5);
    disp(5, 3); #1;
    checks++; if ({b0, t0} !== {1'b1, 4'd3}) begin errors++; $display("FAIL basic_disp_bypass: got %b/%h expected 1/3", b0, t0); end
    step();
    checks++; if ({b0, t0} !== {1'b1, 4'd3}) begin errors++; $display("FAIL basic_disp_state: got %b/%h expected 1/3", b0, t0); end
    cmt(0, 5, 3, 32'hDEAD); #1;
    checks++; if ({v0, b0} !== {32'hDEAD, 1'b0}) begin errors++; $display("FAIL basic_commit_bypass: got %h/%b expected dead/0", v0, b0); end
    step();
    checks++; if ({v0, b0} !== {32'hDEAD, 1'b0}) begin errors++; $display("FAIL basic_commit_state: got %h/%b expected dead/0", v0, b0); end
  endtask

  task automatic test_rename();
    qry(0, 7);
    disp(7, 2); step();
    disp(7, 6); step();
    checks++; if ({b0, t0} !== {1'b1, 4'd6}) begin errors++; $display("FAIL rename_tag: got %b/%h expected 1/6", b0, t0); end
    cmt(0, 7, 2, 32'h11); #1;
    checks++; if ({v0, b0, t0} !== {32'h11, 1'b1, 4'd6}) begin errors++; $display("FAIL rename_stale_bypass: got %h/%b/%h expected 11/1/6", v0, b0, t0); end
    step();
    checks++; if ({v0, b0, t0} !== {32'h11, 1'b1, 4'd6}) begin errors++; $display("FAIL rename_stale_state: got %h/%b/%h expected 11/1/6", v0, b0, t0); end
    cmt(0, 7, 6, 32'h22); disp(7, 9); #1;
    checks++; if ({v0, b0, t0} !== {32'h22, 1'b1, 4'd9}) begin errors++; $display("FAIL rename_disp_wins_bypass: got %h/%b/%h expected 22/1/9", v0, b0, t0); end
    step();
    checks++; if ({v0, b0, t0} !== {32'h22, 1'b1, 4'd9}) begin errors++; $display("FAIL rename_disp_wins_state: got %h/%b/%h expected 22/1/9", v0, b0, t0); end
  endtask

  task automatic test_dual_commit();
    qry(1, 4);
    disp(4, 2); step();
    cmt(0, 4, 1, 32'hA); cmt(1, 4, 2, 32'hB); #1;
    checks++; if ({v1, b1} !== {32'hB, 1'b0}) begin errors++; $display("FAIL dual_bypass: got %h/%b expected b/0", v1, b1); end
    step();
    checks++; if ({v1, b1} !== {32'hB, 1'b0}) begin errors++; $display("FAIL dual_state: got %h/%b expected b/0", v1, b1); end
    qry(0, 0);
    cmt(0, 0, 0, 32'h55); disp(0, 3); #1;
    checks++; if ({v0, b0, t0} !== {32'h0, 1'b0, 4'h0}) begin errors++; $display("FAIL x0_bypass: got %h/%b/%h expected 0/0/0", v0, b0, t0); end
    step();
    checks++; if ({v0, b0, t0} !== {32'h0, 1'b0, 4'h0}) begin errors++; $display("FAIL x0_state: got %h/%b/%h expected 0/0/0", v0, b0, t0); end
  endtask

  task automatic test_ckpt_restore();
    qry(0, 3); qry(1, 8);
    disp(3, 1); step();
    checks++; if (ckpt_id !== 2'd0) begin errors++; $display("FAIL save_id_before: got %0d expected 0", ckpt_id); end
    ckpt_save = 1'b1; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd1, 1'b0}) begin errors++; $display("FAIL save_id_after: got %0d/%b expected 1/0", ckpt_id, ckpt_full); end
    disp(3, 5); step();
    disp(8, 4); step();
    checks++; if ({b0, t0, b1} !== {1'b1, 4'd5, 1'b1}) begin errors++; $display("FAIL spec_busy: got %b/%h/%b expected 1/5/1", b0, t0, b1); end
    cmt(0, 3, 1, 32'h33); step();
    checks++; if ({v0, b0, t0} !== {32'h33, 1'b1, 4'd5}) begin errors++; $display("FAIL old_commit: got %h/%b/%h expected 33/1/5", v0, b0, t0); end
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; step();
    checks++; if ({v0, b0, t0} !== {32'h33, 1'b0, 4'd1}) begin errors++; $display("FAIL restore_x3: got %h/%b/%h expected 33/0/1", v0, b0, t0); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL restore_x8: got %b expected 0", b1); end
    qry(1, 7); #1;
    checks++; if ({b1, t1} !== {1'b1, 4'd9}) begin errors++; $display("FAIL restore_x7: got %b/%h expected 1/9", b1, t1); end
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b0}) begin errors++; $display("FAIL restore_ptrs: got %0d/%b expected 0/0", ckpt_id, ckpt_full); end
  endtask

  task automatic test_ckpt_full();
    logic [1:0] exp_id [4];
    logic       exp_full [4];
    exp_id   = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_full = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      ckpt_save = 1'b1; step();
      checks++; if ({ckpt_id, ckpt_full} !== {exp_id[i], exp_full[i]}) begin errors++; $display("FAIL fill_%0d: got %0d/%b expected %0d/%b", i, ckpt_id, ckpt_full, exp_id[i], exp_full[i]); end
    end
    ckpt_save = 1'b1; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b1}) begin errors++; $display("FAIL save_when_full: got %0d/%b expected 0/1", ckpt_id, ckpt_full); end
    ckpt_release = 1'b1; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b0}) begin errors++; $display("FAIL release: got %0d/%b expected 0/0", ckpt_id, ckpt_full); end
    ckpt_save = 1'b1; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd1, 1'b1}) begin errors++; $display("FAIL wrap_save: got %0d/%b expected 1/1", ckpt_id, ckpt_full); end
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd3; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd3, 1'b0}) begin errors++; $display("FAIL mid_restore: got %0d/%b expected 3/0", ckpt_id, ckpt_full); end
    ckpt_save = 1'b1; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b0}) begin errors++; $display("FAIL refill_1: got %0d/%b expected 0/0", ckpt_id, ckpt_full); end
    ckpt_save = 1'b1; step();
    checks++; if ({ckpt_id, ckpt_full} !== {2'd1, 1'b1}) begin errors++; $display("FAIL refill_2: got %0d/%b expected 1/1", ckpt_id, ckpt_full); end
  endtask

  task automatic test_flush();
    qry(0, 9); qry(1, 7);
    disp(9, 7); step();
    checks++; if ({b0, b1} !== 2'b11) begin errors++; $display("FAIL preflush_busy: got %b%b expected 11", b0, b1); end
    flush_in = 1'b1; cmt(0, 9, 0, 32'h77); disp(10, 1);
    ckpt_save = 1'b1; ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; ckpt_release = 1'b1;
    step();
    checks++; if ({v0, b0, b1} !== {32'h77, 1'b0, 1'b0}) begin errors++; $display("FAIL flush_regs: got %h/%b/%b expected 77/0/0", v0, b0, b1); end
    qry(1, 10); #1;
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL flush_disp_dropped: got %b expected 0", b1); end
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b0}) begin errors++; $display("FAIL flush_ptrs: got %0d/%b expected 0/0", ckpt_id, ckpt_full); end
    for (int i = 0; i < 4; i++) begin
      ckpt_save = 1'b1; step();
    end
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b1}) begin errors++; $display("FAIL flush_count: got %0d/%b expected 0/1", ckpt_id, ckpt_full); end
  endtask

  task automatic test_rdy();
    qry(0, 12);
    rdy_in = 1'b0; disp(12, 5); cmt(0, 12, 0, 32'h99); ckpt_release = 1'b1; #1;
    checks++; if ({v0, b0, t0} !== {32'h99, 1'b1, 4'd5}) begin errors++; $display("FAIL stall_bypass: got %h/%b/%h expected 99/1/5", v0, b0, t0); end
    step();
    checks++; if ({v0, b0} !== {32'h0, 1'b0}) begin errors++; $display("FAIL stall_hold: got %h/%b expected 0/0", v0, b0); end
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b1}) begin errors++; $display("FAIL stall_ckpt: got %0d/%b expected 0/1", ckpt_id, ckpt_full); end
  endtask

  task automatic test_async_reset();
    qry(0, 5); qry(1, 7);
    disp(7, 2); step();
    checks++; if ({v0, b1} !== {32'hDEAD, 1'b1}) begin errors++; $display("FAIL prereset_state: got %h/%b expected dead/1", v0, b1); end
    #2 rst_in = 1'b1; #1;
    checks++; if ({v0, v1, b1, t1} !== {32'h0, 32'h0, 1'b0, 4'h0}) begin errors++; $display("FAIL async_regs: got %h/%h/%b/%h expected 0/0/0/0", v0, v1, b1, t1); end
    checks++; if ({ckpt_id, ckpt_full} !== {2'd0, 1'b0}) begin errors++; $display("FAIL async_ckpt: got %0d/%b expected 0/0", ckpt_id, ckpt_full); end
    #3 rst_in = 1'b0;
    @(posedge clk_in); #1;
    disp(5, 4); step();
    checks++; if ({v0, b0, t0} !== {32'h0, 1'b1, 4'd4}) begin errors++; $display("FAIL post_reset: got %h/%b/%h expected 0/1/4", v0, b0, t0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rename();
    test_dual_commit();
    test_ckpt_restore();
    test_ckpt_full();
    test_flush();
    test_rdy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
